fifo_byte_packer: RTL

- Consumer stage directly downstream of the sync FIFO (show-ahead, zero read delay).
- Pops 8-bit bytes from the FIFO and packs BYTES_PER_WORD of them into one word.
- Presents each word on a valid/ready output port; also counts emitted words.
- Feeds wide-datapath logic; the FIFO absorbs upstream byte bursts.

---
 rtl/fifo_byte_packer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifo_byte_packer.sv
// Packs bytes popped from a show-ahead FIFO into BYTES_PER_WORD-byte words on a valid/ready port.
// Define PACK_TIMEOUT_EN to flush a partial word after TIMEOUT idle cycles.
module fifo_byte_packer #(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned TIMEOUT        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fifo_rdy_i,
    input  logic [7:0]                  fifo_data_i,
    output logic                        fifo_rd_o,
    output logic [8*BYTES_PER_WORD-1:0] word_o,
    output logic [BYTES_PER_WORD-1:0]   keep_o,
    output logic                        word_vld_o,
    input  logic                        word_rdy_i,
    output logic [15:0]                 word_cnt_o
);

    localparam int unsigned IDX_W  = $clog2(BYTES_PER_WORD);
    localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
        $error("fifo_byte_packer: parameter out of range");
    end

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [WORD_W-1:0]         word_q, word_d;
    logic [BYTES_PER_WORD-1:0] keep_q, keep_d;
    logic                      vld_q, vld_d;
    logic [15:0]               cnt_q, cnt_d;
    logic                      pop_c;

`ifdef PACK_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);
    logic [7:0]                idle_q, idle_d;
`endif

    // Pop only while filling; the FIFO head is valid whenever fifo_rdy_i is high.
    assign pop_c     = (state_q == FILL) && fifo_rdy_i;
    assign fifo_rd_o = pop_c;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        keep_d  = keep_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
`ifdef PACK_TIMEOUT_EN
        idle_d  = idle_q;
`endif
        case (state_q)
            FILL: begin
                if (pop_c) begin
                    word_d[{idx_q, 3'b000} +: 8] = fifo_data_i;
                    keep_d[idx_q]                = 1'b1;
`ifdef PACK_TIMEOUT_EN
                    idle_d = 8'd0;
`endif
                    if (idx_q == LAST_IDX) begin
                        state_d = HOLD;
                        vld_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
`ifdef PACK_TIMEOUT_EN
                // Idle with a partial word: flush it once the counter hits TIMEOUT.
                else if (idx_q != '0) begin
                    idle_d = idle_q + 8'd1;
                    if (idle_d == TIMEOUT_LIM) begin
                        state_d = HOLD;
                        vld_d   = 1'b1;
                    end
                end
`endif
            end
            HOLD: begin
                if (word_rdy_i) begin
                    state_d = FILL;
                    vld_d   = 1'b0;
                    keep_d  = '0;
                    idx_d   = '0;
                    cnt_d   = cnt_q + 16'd1;
`ifdef PACK_TIMEOUT_EN
                    idle_d  = 8'd0;
`endif
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            word_q  <= '0;
            keep_q  <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= 16'd0;
`ifdef PACK_TIMEOUT_EN
            idle_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            keep_q  <= keep_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
`ifdef PACK_TIMEOUT_EN
            idle_q  <= idle_d;
`endif
        end
    end

    assign word_o     = word_q;
    assign keep_o     = keep_q;
    assign word_vld_o = vld_q;
    assign word_cnt_o = cnt_q;

endmodule
